// File: rtl/soc2_uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : soc2_uart_tx_arb
// Purpose  : Round-robin byte arbiter in front of the shared UART TX engine.
//            Two requesters (0 = CPU register path, 1 = debug console) each
//            offer one byte at a time. A per-byte lock keeps multi-byte
//            messages together, and a lock budget forces a periodic yield.
//            Each byte is launched with a one-cycle start pulse and tracked
//            through the engine's busy signal. An engine that never raises
//            busy is flagged with a sticky error.
// Revision : 1.0 - initial release
// ============================================================================
module soc2_uart_tx_arb #(
    parameter int START_TIMEOUT = 64,  // must be >= 2
    parameter int LOCK_MAX      = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_lock,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_lock,
    output logic       req1_ready,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    output logic       grant_id,
    output logic       arb_busy,
    output logic       err_timeout,
    input  logic       err_clr
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_to_w = $clog2(START_TIMEOUT + 1);
    localparam int c_lc_w = $clog2(LOCK_MAX + 1);

    // The counter is cleared in LAUNCH and reads 0 in the first WAIT_BUSY
    // cycle. Deciding the timeout when it reads START_TIMEOUT-2 makes the
    // registered error flag appear exactly START_TIMEOUT cycles after the
    // start pulse.
    localparam logic [c_to_w-1:0] c_to_last  = c_to_w'(START_TIMEOUT - 2);
    localparam logic [c_to_w-1:0] c_to_one   = c_to_w'(1);
    localparam logic [c_lc_w-1:0] c_lock_max = c_lc_w'(LOCK_MAX);
    localparam logic [c_lc_w-1:0] c_lc_one   = c_lc_w'(1);

    localparam logic [1:0] c_st_idle      = 2'd0;
    localparam logic [1:0] c_st_launch    = 2'd1;
    localparam logic [1:0] c_st_wait_busy = 2'd2;
    localparam logic [1:0] c_st_wait_done = 2'd3;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [7:0]        r_tx_data;
    logic              r_grant_id;
    logic              r_last;
    logic              r_locked;
    logic [c_lc_w-1:0] r_lock_cnt;
    logic [c_to_w-1:0] r_to_cnt;
    logic              r_err_timeout;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [1:0] w_state_nxt;
    logic       w_lock_hold;   // lock currently restricts eligibility
    logic       w_owner_lock;  // lock input of the current owner
    logic       w_elig0;
    logic       w_elig1;
    logic       w_pick;        // winning requester index
    logic       w_accept;      // handshake this cycle
    logic       w_acc_lock;    // lock bit of the accepted byte
    logic       w_to_hit;      // start timeout fires this cycle

    // Arbitration: lock restricts eligibility to the owner unless the lock
    // budget is used up, in which case this arbitration is plain round-robin.
    always_comb begin
        w_lock_hold  = r_locked && (r_lock_cnt < c_lock_max);
        w_owner_lock = r_grant_id ? req1_lock : req0_lock;
        w_elig0      = req0_valid && !(w_lock_hold && r_grant_id);
        w_elig1      = req1_valid && !(w_lock_hold && !r_grant_id);
        w_pick       = 1'b0;
        if (w_elig0 && w_elig1) begin
            w_pick = ~r_last;
        end else begin
            w_pick = w_elig1;
        end
        w_accept   = (r_state == c_st_idle) && (w_elig0 || w_elig1);
        w_acc_lock = w_pick ? req1_lock : req0_lock;
    end

    // Ready is gated by reset so no requester sees an accept while held.
    assign req0_ready = resetn && w_accept && !w_pick;
    assign req1_ready = resetn && w_accept && w_pick;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and timeout detection.
    always_comb begin
        w_state_nxt = r_state;
        w_to_hit    = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_state_nxt = c_st_launch;
                end
            end
            c_st_launch: begin
                w_state_nxt = c_st_wait_busy;
            end
            c_st_wait_busy: begin
                if (tx_busy) begin
                    w_state_nxt = c_st_wait_done;
                end else if (r_to_cnt == c_to_last) begin
                    w_to_hit    = 1'b1;
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_wait_done: begin
                if (!tx_busy) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Byte, grant and round-robin pointer capture on handshake only.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tx_data  <= 8'h00;
            r_grant_id <= 1'b0;
            r_last     <= 1'b1;
        end else if (w_accept) begin
            r_tx_data  <= w_pick ? req1_data : req0_data;
            r_grant_id <= w_pick;
            r_last     <= w_pick;
        end
    end

    // Lock ownership and consecutive locked-byte budget.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_locked   <= 1'b0;
            r_lock_cnt <= '0;
        end else if (w_accept) begin
            if (w_acc_lock) begin
                r_locked   <= 1'b1;
                // A byte accepted under a still-valid lock extends the run;
                // anything else starts a fresh run of one.
                r_lock_cnt <= w_lock_hold ? (r_lock_cnt + c_lc_one) : c_lc_one;
            end else begin
                r_locked   <= 1'b0;
                r_lock_cnt <= '0;
            end
        end else if (w_to_hit) begin
            // Dropped byte ends any message in progress.
            r_locked   <= 1'b0;
            r_lock_cnt <= '0;
        end else if ((r_state == c_st_idle) && r_locked && !w_owner_lock) begin
            r_locked   <= 1'b0;
            r_lock_cnt <= '0;
        end
    end

    // Start timeout counter: cleared on launch, counts idle WAIT_BUSY cycles.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_to_cnt <= '0;
        end else if (r_state == c_st_launch) begin
            r_to_cnt <= '0;
        end else if ((r_state == c_st_wait_busy) && !tx_busy && !w_to_hit) begin
            r_to_cnt <= r_to_cnt + c_to_one;
        end
    end

    // Sticky timeout flag; a simultaneous set overrides the clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_err_timeout <= 1'b0;
        end else if (w_to_hit) begin
            r_err_timeout <= 1'b1;
        end else if (err_clr) begin
            r_err_timeout <= 1'b0;
        end
    end

    assign tx_start    = (r_state == c_st_launch);
    assign tx_data     = r_tx_data;
    assign grant_id    = r_grant_id;
    assign arb_busy    = (r_state != c_st_idle);
    assign err_timeout = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_soc2_uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc2_uart_tx_arb
// Purpose  : Self-checking bench for soc2_uart_tx_arb. Requesters are byte
//            queues, the TX engine is a busy-timeline generator, and the
//            expected arbiter behaviour is derived from a timeline model
//            (when the arbiter is free, which requester the rotation and lock
//            rules select, when the error flag must rise).
// Revision : 1.0 - initial release
// ============================================================================
module tb_soc2_uart_tx_arb;

    localparam int c_to   = 64;
    localparam int c_lmax = 4;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } item_t;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       req0_valid = 1'b0;
    logic [7:0] req0_data = 8'h00;
    logic       req0_lock = 1'b0;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [7:0] req1_data = 8'h00;
    logic       req1_lock = 1'b0;
    logic       req1_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy = 1'b0;
    logic       grant_id;
    logic       arb_busy;
    logic       err_timeout;
    logic       err_clr = 1'b0;

    soc2_uart_tx_arb #(
        .START_TIMEOUT(c_to),
        .LOCK_MAX     (c_lmax)
    ) u_dut (
        .clk        (clk),
        .resetn     (resetn),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_lock  (req0_lock),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_lock  (req1_lock),
        .req1_ready (req1_ready),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .grant_id   (grant_id),
        .arb_busy   (arb_busy),
        .err_timeout(err_timeout),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    // Scoreboard counters
    int n_checks = 0;
    int n_pass   = 0;

    // Stimulus state
    item_t q0[$];
    item_t q1[$];
    bit    gate_rand = 1'b0;
    bit    clr_pulse = 1'b0;
    int    pol_dly   = 1;     // 0 = random, >= c_to = engine never starts
    int    pol_len   = 1;     // 0 = random
    int    r0_seen   = 0;

    // Reference model state
    int         cyc       = 0;
    int         idle_from = 0;
    int         s_cyc     = 0;
    int         bon       = 0;
    int         boff      = 0;
    int         err_at    = 0;
    bit         err_pending = 1'b0;
    bit         launched  = 1'b0;
    int         n_hs      = 0;
    bit         m_last    = 1'b1;
    bit         m_locked  = 1'b0;
    int         m_lcnt    = 0;
    bit         m_grant   = 1'b0;
    logic [7:0] m_data    = 8'h00;
    bit         m_err     = 1'b0;
    logic [7:0] launch_log[$];
    bit         grant_log[$];

    logic [7:0] exp_cont [4] = '{8'h11, 8'h22, 8'h11, 8'h22};
    logic [7:0] exp_lock [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hB0};
    logic [7:0] exp_yld  [5] = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hD0};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic item_t mk(input logic [7:0] d, input logic l);
        item_t it;
        it.d = d;
        it.l = l;
        return it;
    endfunction

    task automatic model_reset();
        idle_from   = cyc;
        launched    = 1'b0;
        bon         = 0;
        boff        = 0;
        err_pending = 1'b0;
        m_last      = 1'b1;
        m_locked    = 1'b0;
        m_lcnt      = 0;
        m_grant     = 1'b0;
        m_data      = 8'h00;
        m_err       = 1'b0;
    endtask

    // One clock cycle: drive at negedge, compare, then advance the model.
    task automatic step();
        bit    vld [2];
        bit    lck [2];
        bit    free, hold, won, g0, g1;
        int    w, r, dly, len;
        item_t it;
        @(negedge clk);
        g0 = gate_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        g1 = gate_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        req0_valid = (q0.size() > 0) && g0;
        req0_data  = (q0.size() > 0) ? q0[0].d : 8'h00;
        req0_lock  = (q0.size() > 0) ? q0[0].l : 1'b0;
        req1_valid = (q1.size() > 0) && g1;
        req1_data  = (q1.size() > 0) ? q1[0].d : 8'h00;
        req1_lock  = (q1.size() > 0) ? q1[0].l : 1'b0;
        tx_busy    = launched && (cyc >= bon) && (cyc < boff);
        err_clr    = clr_pulse;
        #1;
        vld[0] = req0_valid;
        vld[1] = req1_valid;
        lck[0] = req0_lock;
        lck[1] = req1_lock;
        free = (cyc >= idle_from);
        hold = m_locked && (m_lcnt < c_lmax);
        won  = 1'b0;
        w    = 0;
        // Scan requesters starting just after the one served last.
        for (int k = 0; k < 2; k++) begin
            r = (int'(m_last) + 1 + k) % 2;
            if (!won && free && vld[r] && (!hold || r == int'(m_grant))) begin
                won = 1'b1;
                w   = r;
            end
        end
        check_eq("req0_ready", req0_ready, won && (w == 0));
        check_eq("req1_ready", req1_ready, won && (w == 1));
        if (req0_ready) r0_seen++;
        check_eq("arb_busy", arb_busy, !free);
        check_eq("tx_start", tx_start, launched && (cyc == s_cyc));
        check_eq("tx_data", tx_data, m_data);
        check_eq("grant_id", grant_id, m_grant);
        check_eq("err_timeout", err_timeout, m_err);
        @(posedge clk);
        if (won) begin
            it = (w == 1) ? q1.pop_front() : q0.pop_front();
            m_data  = it.d;
            m_grant = (w == 1);
            m_last  = (w == 1);
            launch_log.push_back(it.d);
            grant_log.push_back(w == 1);
            n_hs++;
            if (it.l) begin
                m_lcnt   = hold ? m_lcnt + 1 : 1;
                m_locked = 1'b1;
            end else begin
                m_lcnt   = 0;
                m_locked = 1'b0;
            end
            s_cyc    = cyc + 1;
            launched = 1'b1;
            if (pol_dly > 0) dly = pol_dly;
            else dly = ($urandom_range(0, 24) == 0) ? 999 : int'($urandom_range(1, 4));
            len = (pol_len > 0) ? pol_len : int'($urandom_range(1, 4));
            if (dly >= c_to) begin
                idle_from   = s_cyc + c_to;
                bon         = 0;
                boff        = 0;
                err_pending = 1'b1;
                err_at      = s_cyc + c_to;
                m_locked    = 1'b0;
                m_lcnt      = 0;
            end else begin
                bon       = s_cyc + dly;
                boff      = bon + len;
                idle_from = boff + 1;
            end
        end else if (free && m_locked && !lck[int'(m_grant)]) begin
            m_locked = 1'b0;
            m_lcnt   = 0;
        end
        if (err_pending && (cyc + 1 == err_at)) begin
            m_err       = 1'b1;
            err_pending = 1'b0;
        end else if (err_clr) begin
            m_err = 1'b0;
        end
        cyc++;
        clr_pulse = 1'b0;
        #1;
    endtask

    // Asynchronous reset with immediate output checks.
    task automatic do_reset();
        #2;
        resetn     = 1'b0;
        tx_busy    = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check_eq("rst_tx_start", tx_start, 1'b0);
        check_eq("rst_arb_busy", arb_busy, 1'b0);
        check_eq("rst_tx_data", tx_data, 8'h00);
        check_eq("rst_grant_id", grant_id, 1'b0);
        check_eq("rst_err", err_timeout, 1'b0);
        check_eq("rst_ready0", req0_ready, 1'b0);
        check_eq("rst_ready1", req1_ready, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        err_clr    = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        resetn = 1'b1;
        model_reset();
    endtask

    task automatic run_until(input int target, input int budget);
        int n = 0;
        while (n_hs < target && n < budget) begin
            step();
            n++;
        end
        check_eq("hs_bound", n_hs >= target, 1'b1);
    endtask

    task automatic run_to_cycle(input int c, input int budget);
        int n = 0;
        while (cyc < c && n < budget) begin
            step();
            n++;
        end
        check_eq("cyc_bound", cyc, c);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q0.size() + q1.size() > 0 || cyc < idle_from) && n < budget) begin
            step();
            n++;
        end
        check_eq("drain_bound", q0.size() + q1.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Continuous contention after reset: strict alternation from req0.
        pol_dly = 1; pol_len = 2;
        launch_log.delete(); grant_log.delete();
        for (int i = 0; i < 2; i++) begin
            q0.push_back(mk(8'h11, 1'b0));
            q1.push_back(mk(8'h22, 1'b0));
        end
        drain(200);
        check_eq("cont_count", launch_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("cont_data%0d", i), launch_log[i], exp_cont[i]);
            check_eq($sformatf("cont_grant%0d", i), grant_log[i], i % 2);
        end

        // Single byte, engine busy for 10 cycles.
        pol_dly = 1; pol_len = 10;
        q0.push_back(mk(8'h5A, 1'b0));
        run_until(n_hs + 1, 20);
        check_eq("single_start", tx_start, 1'b1);
        check_eq("single_data", tx_data, 8'h5A);
        run_to_cycle(boff, 40);
        check_eq("single_busy_hold", arb_busy, 1'b1);
        step();
        check_eq("single_busy_fall", arb_busy, 1'b0);
        drain(40);

        // Lock: req1 sends a locked 3-byte run, req0 must wait.
        pol_dly = 2; pol_len = 3;
        launch_log.delete(); grant_log.delete();
        for (int i = 0; i < 3; i++) q1.push_back(mk(8'hA0 + 8'(i), 1'b1));
        run_until(n_hs + 1, 10);
        q0.push_back(mk(8'hB0, 1'b0));
        r0_seen = 0;
        run_until(n_hs + 2, 60);
        check_eq("lock_r0_ready_low", r0_seen, 0);
        drain(100);
        check_eq("lock_count", launch_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("lock_data%0d", i), launch_log[i], exp_lock[i]);
        end

        // Lock yield after LOCK_MAX consecutive locked bytes.
        do_reset();
        pol_dly = 1; pol_len = 1;
        launch_log.delete(); grant_log.delete();
        for (int i = 0; i < 6; i++) q0.push_back(mk(8'hC0 + 8'(i), 1'b1));
        q1.push_back(mk(8'hD0, 1'b0));
        drain(200);
        check_eq("yield_count", launch_log.size(), 7);
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("yield_data%0d", i), launch_log[i], exp_yld[i]);
            check_eq($sformatf("yield_grant%0d", i), grant_log[i], i == 4);
        end

        // Start timeout, clear, and clear coinciding with a new timeout.
        pol_dly = 999; pol_len = 1;
        q0.push_back(mk(8'h77, 1'b0));
        run_until(n_hs + 1, 10);
        run_to_cycle(s_cyc + c_to - 1, 100);
        check_eq("to_err_early", err_timeout, 1'b0);
        check_eq("to_busy_early", arb_busy, 1'b1);
        step();
        check_eq("to_err_rise", err_timeout, 1'b1);
        check_eq("to_idle", arb_busy, 1'b0);
        clr_pulse = 1'b1;
        step();
        check_eq("to_err_clr", err_timeout, 1'b0);
        q0.push_back(mk(8'h78, 1'b0));
        run_until(n_hs + 1, 10);
        run_to_cycle(s_cyc + c_to - 1, 100);
        clr_pulse = 1'b1;
        step();
        check_eq("to_set_wins", err_timeout, 1'b1);
        clr_pulse = 1'b1;
        step();
        check_eq("to_err_clr2", err_timeout, 1'b0);

        // Reset while the engine is shifting; byte abandoned.
        pol_dly = 1; pol_len = 10;
        q0.push_back(mk(8'h9C, 1'b0));
        run_until(n_hs + 1, 10);
        run_to_cycle(bon + 2, 20);
        check_eq("mid_pre_busy", arb_busy, 1'b1);
        do_reset();
        pol_dly = 1; pol_len = 2;
        launch_log.delete(); grant_log.delete();
        q0.push_back(mk(8'h33, 1'b0));
        q1.push_back(mk(8'h44, 1'b0));
        run_until(n_hs + 1, 10);
        check_eq("mid_first_data", launch_log[0], 8'h33);
        check_eq("mid_first_grant", grant_log[0], 1'b0);
        drain(100);

        // Randomized traffic: gaps, withdrawals, locks, timeouts, clears.
        gate_rand = 1'b1;
        pol_dly = 0; pol_len = 0;
        for (int i = 0; i < 1500; i++) begin
            if (q0.size() < 2 && $urandom_range(0, 1) == 0)
                q0.push_back(mk(8'($urandom), $urandom_range(0, 2) == 0));
            if (q1.size() < 2 && $urandom_range(0, 1) == 0)
                q1.push_back(mk(8'($urandom), $urandom_range(0, 2) == 0));
            clr_pulse = ($urandom_range(0, 39) == 0);
            step();
        end
        gate_rand = 1'b0;
        drain(1000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/soc2_uart_tx_arb.md
# soc2_uart_tx_arb

Byte-level arbiter and sequencer sharing the single UART transmit engine in the `soc2_top` peripheral block between two requesters. Requester 0 is the CPU bus-side UART register path; requester 1 is the debug/console source. The block picks one requester per byte by round-robin and supports a lock so that multi-byte messages are not interleaved. It launches the byte into the TX engine, tracks the engine's busy signal to completion, and flags an engine that never starts.

## Interface
Parameters:
- `START_TIMEOUT`, default 64: cycles allowed between `tx_start` and `tx_busy` rising.
- `LOCK_MAX`, default 16: maximum consecutive locked bytes before the lock is forcibly yielded for one arbitration.

Ports:
- `clk`  in  1  system clock. One clock domain only.
- `resetn`  in  1  reset, asynchronous, active-low.
- `req0_valid`  in  1  requester 0 has a byte.
- `req0_data`  in  8  requester 0 byte. Held stable while `req0_valid` is high.
- `req0_lock`  in  1  requester 0 keeps the grant after this byte.
- `req0_ready`  out  1  requester 0 byte accepted this cycle.
- `req1_valid`, `req1_data`, `req1_lock`, `req1_ready`: same as requester 0, for requester 1.
- `tx_start`  out  1  one-cycle launch pulse to the TX engine.
- `tx_data`  out  8  byte presented to the TX engine.
- `tx_busy`  in  1  TX engine is shifting a frame.
- `grant_id`  out  1  requester owning the current or last byte.
- `arb_busy`  out  1  high whenever the FSM is not in IDLE.
- `err_timeout`  out  1  sticky flag: the engine did not start.
- `err_clr`  in  1  clears `err_timeout`.

## Operation
FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- **IDLE.** Evaluates `reqN_valid`. The winner's `reqN_ready` is asserted combinationally; at most one ready is high. A handshake (`valid & ready`) latches the byte into `tx_data`, sets `grant_id`, and moves the FSM to LAUNCH.
- **Round-robin.** Pointer `last` holds the last requester served. On a tie, `!last` wins. A single valid requester wins regardless of `last`.
- **Lock.** If the accepted byte had `lock=1`, `locked` is set and the owner is the only eligible requester in the next IDLE. The other requester's ready is held low even if the owner is not valid.
  - `locked` clears at any IDLE cycle where the owner's lock input is 0.
  - 3-bit-plus counter `lock_cnt` counts locked bytes. When it reaches `LOCK_MAX`, the next IDLE arbitration ignores the lock (normal round-robin), then `lock_cnt` resets.
- **LAUNCH.** `tx_start=1` for exactly one cycle. `tx_data` is held. Next state is WAIT_BUSY, and the timeout counter is cleared.
- **WAIT_BUSY.** Waits for `tx_busy=1`, then goes to WAIT_DONE.
  - The counter increments each cycle. On reaching `START_TIMEOUT` with `tx_busy` still 0, the FSM sets `err_timeout` and goes to IDLE. The byte is dropped and `locked` is cleared.
- **WAIT_DONE.** Waits for `tx_busy=0`, then goes to IDLE. There is no timeout in this state.
- **Error flag.** `err_timeout` is set by a timeout and cleared by `err_clr`. If both happen in the same cycle, set wins.
- **Data stability.** `tx_data` changes only on a handshake.

## Timing
- **Reset values** (asynchronous on `resetn` low): state IDLE, `tx_start=0`, `tx_data=0`, `grant_id=0`, `arb_busy=0`, `err_timeout=0`, `locked=0`, `lock_cnt=0`, `last=1` (requester 0 wins the first tie). Both `reqN_ready` are forced to 0 while `resetn` is low.
- **Handshake to start:** handshake in cycle N gives `tx_start` high in cycle N+1.
- **Minimum byte occupancy:** IDLE, LAUNCH, WAIT_BUSY (≥1 cycle), WAIT_DONE (≥1 cycle), then back to IDLE. The next accept is possible in the cycle the FSM re-enters IDLE.
- **Timeout detection:** `err_timeout` rises exactly `START_TIMEOUT` cycles after the `tx_start` cycle.
- **Busy already high:** if `tx_busy` is already 1 in the cycle after LAUNCH, WAIT_BUSY lasts exactly one cycle.
- **Reset mid-operation:** an in-flight byte is abandoned, with no retry. `tx_start` drops immediately.
- **Valid withdrawn:** a requester dropping valid without a handshake is legal. No state change results.

## Test plan
- **Single byte, no contention.** Drive `req0_valid=1`, `data=8'h5A`. Expect `req0_ready` in IDLE, `tx_start` one cycle later with `tx_data=8'h5A`. Model `tx_busy` high for 10 cycles. Expect `arb_busy` to fall 1 cycle after `tx_busy` falls.
- **Continuous contention.** Hold both valid with `data0=8'h11`, `data1=8'h22`. Expect the `tx_data` sequence `11,22,11,22` and `grant_id` alternating `0,1,0,1`.
- **Lock.** `req1_lock=1` for 3 bytes (`8'hA0..A2`) while `req0_valid=1`. Expect A0, A1, A2 first, then req0's byte. Expect `req0_ready` to stay low throughout the locked run.
- **Lock yield.** With `LOCK_MAX=4`, hold `req0_lock=1` permanently with req1 valid. Expect req1 to be granted after 4 consecutive req0 bytes.
- **Start timeout.** Keep `tx_busy` at 0. Expect `err_timeout=1` exactly 64 cycles after `tx_start` and the FSM back in IDLE. Pulse `err_clr` and expect the flag cleared next cycle. With clear and timeout in the same cycle, expect the flag to stay 1.
- **Reset mid-frame.** Assert `resetn=0` during WAIT_DONE. Expect all outputs to reset values immediately. After release, req0 wins the first tie.
